// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns store lanes, extends loads, stalls upstream until the bus acks.
// Latency 2 + ack wait cycles; optional ack watchdog under MEM_TIMEOUT_EN (TIMEOUT_CYC limit).
module mem_access_unit #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_step,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic                    i_signed,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic [NB-1:0]           i_addr,
  input  logic [NB-1:0]           i_wdata,
  output logic                    o_dmem_req,
  output logic                    o_dmem_we,
  output logic [NB-1:0]           o_dmem_addr,
  output logic [NB/8-1:0]         o_dmem_be,
  output logic [NB-1:0]           o_dmem_wdata,
  input  logic                    i_dmem_ack,
  input  logic [NB-1:0]           i_dmem_rdata,
  output logic                    o_stall,
  output logic                    o_valid,
  output logic [NB-1:0]           o_read_data,
  output logic                    o_misaligned,
  output logic                    o_bus_error
);

  localparam int NBE = NB / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  state_t          state_q, state_d;
  size_t           size_q, size_d, req_size;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            signed_q, signed_d;
  logic [NB-1:0]   dmem_addr_q, dmem_addr_d;
  logic [1:0]      off_q, off_d;
  logic [NBE-1:0]  be_q, be_d;
  logic [NB-1:0]   wdata_q, wdata_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [NB-1:0]   read_data_q, read_data_d;

  logic            access, misaligned, accept;
  logic [NBE-1:0]  st_be;
  logic [NB-1:0]   st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [NB-1:0]   ld_ext;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buserr_q, buserr_d;
`else
  logic             unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Request decode and store lane placement, all from the live EX/MEM inputs.
  always_comb begin
    req_size = SZ_WORD;
    if (i_word_size == NB_SIZE_TYPE'(0)) begin
      req_size = SZ_BYTE;
    end else if (i_word_size == NB_SIZE_TYPE'(1)) begin
      req_size = SZ_HALF;
    end

    misaligned = ((req_size == SZ_HALF) && i_addr[0]) ||
                 ((req_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    access     = i_step & (i_mem_read | i_mem_write);
    accept     = (state_q == IDLE) && access && !misaligned;

    st_be    = '1;
    st_wdata = i_wdata;
    case (req_size)
      SZ_BYTE: begin
        st_be    = NBE'(1) << i_addr[1:0];
        st_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        st_be    = '1;
        st_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = i_dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: ld_ext = {{(NB-8){signed_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{(NB-16){signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    signed_d    = signed_q;
    dmem_addr_d = dmem_addr_q;
    off_d       = off_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    valid_d     = 1'b0;
    mis_d       = 1'b0;
    read_data_d = read_data_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    buserr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            // A simultaneous read+write is taken as a store.
            state_d     = REQ;
            req_d       = 1'b1;
            we_d        = i_mem_write;
            signed_d    = i_signed;
            dmem_addr_d = {i_addr[NB-1:2], 2'b00};
            off_d       = i_addr[1:0];
            be_d        = i_mem_write ? st_be : '1;
            wdata_d     = st_wdata;
            size_d      = req_size;
`ifdef MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      REQ: begin
        if (i_dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          if (!we_q) begin
            read_data_d = ld_ext;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d  = DONE;
          req_d    = 1'b0;
          buserr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      dmem_addr_q <= '0;
      off_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_BYTE;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      read_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      buserr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      signed_q    <= signed_d;
      dmem_addr_q <= dmem_addr_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      read_data_q <= read_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      buserr_q    <= buserr_d;
`endif
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = dmem_addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_valid      = valid_q;
  assign o_misaligned = mis_q;
  assign o_read_data  = read_data_q;
  // Stall rises in the accepting cycle so upstream holds before the request launches.
  assign o_stall      = (state_q == REQ) || accept;
`ifdef MEM_TIMEOUT_EN
  assign o_bus_error  = buserr_q;
`else
  assign o_bus_error  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a byte-addressed memory model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        i_step, i_mem_read, i_mem_write, i_signed;
  logic [2:0]  i_word_size;
  logic [31:0] i_addr, i_wdata;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_valid, o_misaligned, o_bus_error;
  logic [31:0] o_read_data;

  mem_access_unit #(.NB(32), .NB_SIZE_TYPE(3), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_step(i_step), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_signed(i_signed), .i_word_size(i_word_size),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall),
    .o_valid(o_valid), .o_read_data(o_read_data), .o_misaligned(o_misaligned),
    .o_bus_error(o_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic [2:0] flags; logic [31:0] rdata; } res_exp_t;  // flags = {valid, misaligned, bus_error}

  bus_exp_t    bus_q[$];
  res_exp_t    res_q[$];
  logic [31:0] dev_mem [256];
  logic [7:0]  mb [1024];
  logic [31:0] last_load;
  int          next_wait = 0;
  bit          resp_en = 1'b1;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_step = 0; i_mem_read = 0; i_mem_write = 0; i_signed = 0;
    i_word_size = 0; i_addr = 0; i_wdata = 0;
  endtask

  task automatic junk_inputs();
    i_step = 1'($urandom); i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
    i_signed = 1'($urandom); i_word_size = 3'($urandom); i_addr = $urandom; i_wdata = $urandom;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    dev_mem[a[9:2]] = w;
    for (int i = 0; i < 4; i++) mb[{a[9:2], 2'b00} + i] = w[8*i +: 8];
  endtask

  // Memory slave: acks after next_wait REQ cycles, plus stray acks while idle.
  initial begin
    int cnt;
    bit given;
    cnt = 0; given = 0;
    i_dmem_ack = 0; i_dmem_rdata = 0;
    forever begin
      @(negedge clk);
      i_dmem_ack = 0;
      i_dmem_rdata = $urandom;
      if (o_dmem_req) begin
        if (!given && resp_en) begin
          if (cnt >= next_wait) begin
            i_dmem_ack = 1; given = 1;
            i_dmem_rdata = dev_mem[o_dmem_addr[9:2]];
            if (o_dmem_we)
              for (int b = 0; b < 4; b++)
                if (o_dmem_be[b]) dev_mem[o_dmem_addr[9:2]][8*b +: 8] = o_dmem_wdata[8*b +: 8];
          end else cnt++;
        end
      end else begin
        cnt = 0; given = 0;
        if ($urandom_range(0, 3) == 0) i_dmem_ack = 1;
      end
    end
  end

  // Monitor: checks every bus request launch and every completion event against the queues.
  initial begin
    logic req_prev;
    bus_exp_t be_e;
    res_exp_t re_e;
    req_prev = 0;
    forever begin
      @(negedge clk);
      if (o_dmem_req && !req_prev) begin
        if (bus_q.size() == 0) check("unexpected_req", 32'(o_dmem_req), 32'd0);
        else begin
          be_e = bus_q.pop_front();
          check("bus_we", 32'(o_dmem_we), 32'(be_e.we));
          check("bus_addr", o_dmem_addr, be_e.addr);
          check("bus_be", 32'(o_dmem_be), 32'(be_e.be));
          if (be_e.we) check("bus_wdata", o_dmem_wdata, be_e.wdata);
        end
      end
      req_prev = o_dmem_req;
      if (o_valid || o_misaligned || o_bus_error) begin
        if (res_q.size() == 0) check("unexpected_resp", 32'({o_valid, o_misaligned, o_bus_error}), 32'd0);
        else begin
          re_e = res_q.pop_front();
          check("resp_flags", 32'({o_valid, o_misaligned, o_bus_error}), 32'(re_e.flags));
          check("read_data", o_read_data, re_e.rdata);
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input bit sg, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit st, input bit to_exp);
    bit acc, mis, done;
    int n, lat, stl;
    logic [31:0] v;
    bus_exp_t b;
    @(posedge clk); #1;
    acc = st && (rd || wr);
    n   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    i_step = st; i_mem_read = rd; i_mem_write = wr; i_signed = sg;
    i_word_size = sz; i_addr = a; i_wdata = wd;
    if (acc && mis) res_q.push_back('{3'b010, last_load});
    else if (acc) begin
      b.we = wr; b.addr = {a[31:2], 2'b00}; b.be = 4'hF; b.wdata = wd;
      if (wr) begin
        if (n == 1) begin b.be = 4'b0001 << a[1:0]; b.wdata = {4{wd[7:0]}}; end
        else if (n == 2) begin b.be = a[1] ? 4'b1100 : 4'b0011; b.wdata = {2{wd[15:0]}}; end
        for (int i = 0; i < n; i++) mb[a[9:0] + 10'(i)] = wd[8*i +: 8];
        res_q.push_back('{3'b100, last_load});
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[a[9:0] + 10'(i)]) << (8 * i));
        if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
        if (to_exp) res_q.push_back('{3'b001, last_load});
        else begin last_load = v; res_q.push_back('{3'b100, v}); end
      end
      bus_q.push_back(b);
    end
    @(negedge clk);
    check("accept_stall", 32'(o_stall), 32'(acc && !mis));
    stl = int'(o_stall);
    @(posedge clk); #1;
    idle_inputs();
    if (acc) begin
      lat = 0; done = 0;
      while (!done && lat < 200) begin
        @(negedge clk);
        lat++;
        stl += int'(o_stall);
        if (o_valid || o_misaligned || o_bus_error) done = 1;
        if (o_dmem_req) junk_inputs(); else idle_inputs();
      end
      if (!done) check("completion_timeout", 32'(lat), 32'd0);
      else begin
        check("latency", 32'(lat), mis ? 32'd1 : 32'(next_wait + 2));
        check("stall_cycles", 32'(stl), mis ? 32'd0 : 32'(next_wait + 2));
      end
    end else begin
      @(negedge clk);
      check("no_access_req", 32'(o_dmem_req), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    last_load = 0;
    for (int i = 0; i < 256; i++) poke(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(o_dmem_req), 0);
    check("rst_dmem", {o_dmem_we, o_dmem_be, o_dmem_addr[26:0]} | o_dmem_wdata, 0);
    check("rst_flags", 32'({o_stall, o_valid, o_misaligned, o_bus_error}), 0);
    check("rst_read_data", o_read_data, 0);
    rst_n = 1;

    poke(32'h100, 32'h80AABBCC); next_wait = 3;
    issue(1, 0, 1, 3'd0, 32'h103, 0, 1, 0);
    check("lb_signed_result", o_read_data, 32'hFFFFFF80);

    poke(32'h100, 32'h9ABC1234); next_wait = 1;
    issue(1, 0, 0, 3'd1, 32'h102, 0, 1, 0);
    check("lhu_result", o_read_data, 32'h00009ABC);

    next_wait = 0;
    issue(0, 1, 0, 3'd0, 32'h201, 32'h000000EE, 1, 0);
    issue(1, 0, 0, 3'd2, 32'h102, 0, 1, 0);
    check("misaligned_keeps_data", o_read_data, 32'h00009ABC);
    next_wait = 2;
    issue(1, 1, 0, 3'd2, 32'h300, 32'hCAFEF00D, 1, 0);
    issue(1, 0, 0, 3'd2, 32'h300, 0, 1, 0);
    issue(1, 0, 0, 3'd2, 32'h304, 0, 0, 0);

    // Reset while a load is waiting on its ack: request must vanish at once.
    resp_en = 0;
    @(posedge clk); #1;
    i_step = 1; i_mem_read = 1; i_word_size = 3'd2; i_addr = 32'h40;
    bus_q.push_back('{1'b0, 32'h40, 4'hF, 32'h0});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("pre_reset_req", 32'(o_dmem_req), 1);
    #2 rst_n = 0;
    #1;
    check("reset_drops_req", 32'(o_dmem_req), 0);
    check("reset_drops_stall", 32'(o_stall), 0);
    check("reset_clears_data", o_read_data, 0);
    @(posedge clk); #1;
    rst_n = 1; last_load = 0; resp_en = 1;
    poke(32'h40, 32'h12345678); next_wait = 1;
    issue(1, 0, 0, 3'd2, 32'h40, 0, 1, 0);
    check("post_reset_lw", o_read_data, 32'h12345678);

`ifdef MEM_TIMEOUT_EN
    resp_en = 0; next_wait = TO - 1;
    issue(1, 0, 0, 3'd2, 32'h80, 0, 1, 1);
    resp_en = 1; next_wait = TO - 1;
    issue(1, 0, 1, 3'd0, 32'h81, 0, 1, 0);
`endif

    for (int t = 0; t < 300; t++) begin
      next_wait = $urandom_range(0, 5);
      issue(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
            {$urandom_range(0, 255), 14'($urandom), 10'($urandom)},
            $urandom, $urandom_range(0, 7) != 0, 0);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(res_q.size() + bus_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
